sram_ctrl: RTL

Initiator-side controller for the team's synchronous single-port SRAM model. Accepts read/write requests from a host over a valid/ready handshake, drives the SRAM address, read-write bit and tri-stated data bus with correct cycle alignment, and returns read data over a valid/ready response channel. It sits between a bus master or test harness and one SRAM instance of matching `ADDR_WIDTH`/`DATA_WIDTH`.

---
 rtl/sram_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/sram_ctrl.sv
// Host-side controller for the single-port synchronous SRAM: one request at a time, registered address/rwb.
// Optional SRAM_CTRL_TURNAROUND_EN inserts an undriven TA cycle after every read response.

module sram_ctrl #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic                  sram_rwb,
  inout  wire  [DATA_WIDTH-1:0] sram_data
);

  // state | meaning
  // IDLE  | ready for a request, bus released
  // WR    | write cycle, bus driven, SRAM writes at end of cycle
  // RD    | read cycle, SRAM loads its output at end of cycle
  // CAP   | SRAM data on the bus, captured into rsp_rdata at end of cycle
  // RSP   | read response presented until rsp_ready
  // TA    | one undriven turnaround cycle (SRAM_CTRL_TURNAROUND_EN only)
  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    CAP,
    RSP
`ifdef SRAM_CTRL_TURNAROUND_EN
    , TA
`endif
  } state_t;

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  accept;

  assign accept = (state == IDLE) && req_valid;

  // Drive enable is tied to the registered rwb, so the bus is driven only during WR.
  assign sram_data = sram_rwb ? wdata_q : {DATA_WIDTH{1'bz}};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          state_nxt = req_we ? WR : RD;
        end
      end
      WR:  state_nxt = IDLE;
      RD:  state_nxt = CAP;
      CAP: state_nxt = RSP;
      RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
`ifdef SRAM_CTRL_TURNAROUND_EN
          state_nxt = TA;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef SRAM_CTRL_TURNAROUND_EN
      TA:  state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sram_addr <= '0;
      sram_rwb  <= 1'b0;
      wdata_q   <= '0;
      rsp_rdata <= '0;
    end else begin
      sram_rwb <= 1'b0;
      if (accept) begin
        sram_addr <= req_addr;
        wdata_q   <= req_wdata;
        sram_rwb  <= req_we;
      end
      if (state == CAP) begin
        rsp_rdata <= sram_data;
      end
    end
  end

endmodule
